jk_sync_counter: RTL and testbench

- Synchronous modulo-N up/down counter built from a chain of JK flip-flop stages.
- Each bit's next state follows the JK characteristic equation, with J/K derived per bit from lower-order bits.
- Sits downstream of the single JK flip-flop cell and consumes its q/qbar semantics.
- Provides count, complement, terminal-count and load-error outputs for cascading and for event counting in the advanced examples.

---
 rtl/jk_sync_counter.sv | 47 ++++
 tb/tb_jk_sync_counter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down counter built from JK flip-flop stages
module jk_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             load_err
);
    localparam logic [WIDTH:0]   mod_w = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] top   = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] j, k, target, q_next;
    logic oor, at_top, at_zero, frc, run_up, run_dn;
    assign oor     = {1'b0, load_val} >= mod_w;
    assign at_top  = up & (q == top);
    assign at_zero = ~up & (q == '0);
    assign tc      = en & ~load & (at_top | at_zero);
    assign frc     = rst | load | (en & (at_top | at_zero));
    assign target  = rst ? '0 : load ? (oor ? top : load_val) : up ? '0 : top;
    assign qbar    = ~q;
    // J/K per stage: forced to the target on reset/load/wrap, otherwise toggle when all lower bits carry/borrow
    always_comb begin
        run_up = 1'b1;
        run_dn = 1'b1;
        j      = '0;
        k      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            j[i]   = frc ? target[i]  : en & (up ? run_up : run_dn);
            k[i]   = frc ? ~target[i] : en & (up ? run_up : run_dn);
            run_up = run_up & q[i];
            run_dn = run_dn & ~q[i];
        end
    end
    assign q_next = (j & ~q) | (~k & q);
    // JK stage registers and one-cycle out-of-range load flag
    always_ff @(posedge clk) begin
        q        <= q_next;
        load_err <= ~rst & load & oor;
    end
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: directed checks of the JK counter at MODULUS 10 and 16
`timescale 1ms/1us
module tb_jk_sync_counter;
    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] q, qbar, q16, qbar16;
    logic       tc, load_err, tc16, err16;
    int         n_cmp = 0;
    int         n_bad = 0;

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q), .qbar(qbar), .tc(tc), .load_err(load_err)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q16), .qbar(qbar16), .tc(tc16), .load_err(err16)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // complement output must mirror the count on every cycle
    always @(negedge clk) begin
        chk("qbar_inv", 32'(qbar), 32'(4'(~q)));
        chk("qbar16_inv", 32'(qbar16), 32'(4'(~q16)));
    end

    initial begin
        logic [3:0] e;
        rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
        step();
        step();
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qbar", 32'(qbar), 32'hF);
        chk("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("tc_q0_up", 32'(tc), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("up_q", 32'(q), 32'(i));
            chk("up_tc", 32'(tc), 32'(i == 9));
        end
        step();
        chk("wrap_up_q", 32'(q), 32'd0);
        chk("wrap_up_qbar", 32'(qbar), 32'hF);
        chk("wrap_up_tc", 32'(tc), 32'd0);
        up = 1'b0;
        #1;
        chk("dn_tc_q0", 32'(tc), 32'd1);
        en = 1'b0;
        #1;
        chk("dn_tc_noen", 32'(tc), 32'd0);
        en = 1'b1;
        step();
        chk("wrap_dn_q", 32'(q), 32'd9);
        chk("wrap_dn_tc", 32'(tc), 32'd0);
        step();
        chk("dn_q8", 32'(q), 32'd8);
        step();
        chk("dn_q7", 32'(q), 32'd7);
        load = 1'b1; load_val = 4'd6;
        #1;
        chk("load_tc", 32'(tc), 32'd0);
        step();
        chk("load6_q", 32'(q), 32'd6);
        chk("load6_err", 32'(load_err), 32'd0);
        load_val = 4'd12;
        step();
        chk("load12_q", 32'(q), 32'd9);
        chk("load12_err", 32'(load_err), 32'd1);
        load = 1'b0; en = 1'b0;
        step();
        chk("err_drop_q", 32'(q), 32'd9);
        chk("err_drop", 32'(load_err), 32'd0);
        load = 1'b1; load_val = 4'd5;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q", 32'(q), 32'd5);
        end
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd3;
        step();
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_err", 32'(load_err), 32'd0);
        rst = 1'b0; load = 1'b0; up = 1'b1;
        step();
        chk("after_rst_q", 32'(q), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("m16_rst_q", 32'(q16), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            chk("m16_tc", 32'(tc16), 32'(i == 16));
            step();
            e = 4'(i);
            chk("m16_q", 32'(q16), 32'(e));
            chk("m16_qbar", 32'(qbar16), 32'(4'(~e)));
        end
        load = 1'b1; load_val = 4'd15;
        step();
        chk("m16_load15_q", 32'(q16), 32'd15);
        chk("m16_load15_err", 32'(err16), 32'd0);
        chk("m10_load15_q", 32'(q), 32'd9);
        chk("m10_load15_err", 32'(load_err), 32'd1);
        load = 1'b0;
        step();
        chk("m16_wrap_q", 32'(q16), 32'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
